mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_fetch_buf.sv | 55 +++++
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice.
//   ADDR_W / DATA_W : SRAM word-address and data widths.
//   state_e         : arbiter FSM state encoding.
//   src_e           : which requester owns the transaction in flight.
package mem_arbiter_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_RESP  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_INIT = 2'd1,
    SRC_EXE  = 2'd2,
    SRC_IF   = 2'd3
  } src_e;

endpackage

// File: rtl/mem_arbiter_fetch_buf.sv
// One-entry instruction fetch buffer (tag, data, valid).
//   clk, rst          : clock, synchronous active-high reset
//   load, load_tag,
//   load_data         : capture a completed fetch and mark the entry valid
//   inv, inv_addr     : a completed write; clears valid when inv_addr matches the tag
//   lookup_addr       : fetch address to compare against the tag
//   hit, hit_data     : combinational hit flag and buffered word
module fetch_buf
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_tag,
  input  logic [DATA_W-1:0] load_data,
  input  logic              inv,
  input  logic [ADDR_W-1:0] inv_addr,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      tag_d   = load_tag;
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (inv && (inv_addr == tag_q)) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign hit      = valid_q && (tag_q == lookup_addr);
  assign hit_data = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Three-port SRAM arbiter: boot-loader writes, execute loads/stores and
// instruction fetches share one downstream SRAM engine.
//   init_*  : boot-loader write port (req held until init_ack)
//   exe_*   : execute-stage load/store port (req held until exe_ack)
//   if_*    : instruction-fetch read port (req held until if_ack)
//   rdata   : read data, valid while exe_ack (load) or if_ack is high
//   dn_*    : downstream request/ack handshake to the SRAM engine
//   err     : sticky flag, set when dn_ack fails to arrive within TIMEOUT cycles
// Priority is init > exe > if, except that a fetch pending through
// STARVE_LIMIT consecutive other grants wins the next arbitration.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata,
  output logic              init_ack,
  input  logic              exe_req,
  input  logic              exe_we,
  input  logic [ADDR_W-1:0] exe_addr,
  input  logic [DATA_W-1:0] exe_wdata,
  output logic              exe_ack,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              dn_req,
  output logic              dn_we,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [DATA_W-1:0] dn_wdata,
  input  logic              dn_ack,
  input  logic [DATA_W-1:0] dn_rdata,
  output logic              err
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int TM_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  src_e              win;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [TM_W-1:0]   timer_q, timer_d;
  logic              err_q, err_d;

  logic              buf_load, buf_inv, buf_hit;
  logic [DATA_W-1:0] buf_data;

  fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .load_tag   (addr_q),
    .load_data  (dn_rdata),
    .inv        (buf_inv),
    .inv_addr   (addr_q),
    .lookup_addr(if_addr),
    .hit        (buf_hit),
    .hit_data   (buf_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      src_q    <= SRC_NONE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      starve_q <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      starve_q <= starve_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    starve_d = starve_q;
    timer_d  = timer_q;
    err_d    = err_q;
    win      = SRC_NONE;
    buf_load = 1'b0;
    buf_inv  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (if_req && (starve_q == SC_W'(STARVE_LIMIT))) win = SRC_IF;
        else if (init_req)                                win = SRC_INIT;
        else if (exe_req)                                 win = SRC_EXE;
        else if (if_req)                                  win = SRC_IF;
        src_d = win;

        case (win)
          SRC_INIT: begin
            we_d    = 1'b1;
            addr_d  = init_addr;
            wdata_d = init_wdata;
          end
          SRC_EXE: begin
            we_d    = exe_we;
            addr_d  = exe_addr;
            wdata_d = exe_wdata;
          end
          SRC_IF: begin
            we_d   = 1'b0;
            addr_d = if_addr;
          end
          default: ;
        endcase

        if (win == SRC_IF) begin
          starve_d = '0;
          // A buffered fetch bypasses the downstream engine entirely.
          if (buf_hit) begin
            state_d = ST_RESP;
            rdata_d = buf_data;
          end else begin
            state_d = ST_BUSY;
            timer_d = '0;
          end
        end else if (win != SRC_NONE) begin
          state_d = ST_BUSY;
          timer_d = '0;
          if (if_req && (starve_q != SC_W'(STARVE_LIMIT)))
            starve_d = starve_q + SC_W'(1);
        end
      end

      ST_BUSY: begin
        if (dn_ack) begin
          state_d = ST_RESP;
          rdata_d = dn_rdata;
          // Writes invalidate a stale buffered fetch; fetches refill it.
          if (we_q)                 buf_inv  = 1'b1;
          else if (src_q == SRC_IF) buf_load = 1'b1;
        end else if (timer_q == TM_W'(TIMEOUT - 1)) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
          timer_d = timer_q + TM_W'(1);
        end else begin
          timer_d = timer_q + TM_W'(1);
        end
      end

      ST_RESP:  state_d = ST_IDLE;

      ST_ERROR: ;
    endcase
  end

  // Outputs
  always_comb begin
    dn_req   = (state_q == ST_BUSY);
    dn_we    = (state_q == ST_BUSY) && we_q;
    dn_addr  = addr_q;
    dn_wdata = wdata_q;
    init_ack = (state_q == ST_RESP) && (src_q == SRC_INIT);
    exe_ack  = (state_q == ST_RESP) && (src_q == SRC_EXE);
    if_ack   = (state_q == ST_RESP) && (src_q == SRC_IF);
    rdata    = rdata_q;
    err      = err_q;
  end

endmodule
